// File: rtl/decode_pkg.sv
// Shared LEGv8 decode definitions: format codes, opcode patterns and opcode
// classification helpers used by the field extractor.
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_D  = 3'd2,
    FMT_B  = 3'd3,
    FMT_CB = 3'd4,
    FMT_IW = 3'd5
  } fmt_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_MAIN  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [5:0] OP_BL    = 6'b100101;
  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_CBNZ  = 8'b10110101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;
  localparam logic [8:0] OP_MOVZ  = 9'b110100101;
  localparam logic [8:0] OP_MOVK  = 9'b111100101;

  localparam logic [9:0] OP_ADDI  = 10'b1001000100;
  localparam logic [9:0] OP_ADDIS = 10'b1011000100;
  localparam logic [9:0] OP_SUBI  = 10'b1101000100;
  localparam logic [9:0] OP_SUBIS = 10'b1111000100;
  localparam logic [9:0] OP_ANDI  = 10'b1001001000;
  localparam logic [9:0] OP_ANDIS = 10'b1111001000;
  localparam logic [9:0] OP_ORRI  = 10'b1011001000;
  localparam logic [9:0] OP_EORI  = 10'b1101001000;

  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_LDURB  = 11'b00111000010;
  localparam logic [10:0] OP_STURB  = 11'b00111000000;
  localparam logic [10:0] OP_LDURH  = 11'b01111000010;
  localparam logic [10:0] OP_STURH  = 11'b01111000000;
  localparam logic [10:0] OP_LDURSW = 11'b10111000100;
  localparam logic [10:0] OP_STURW  = 11'b10111000000;
  localparam logic [10:0] OP_LDXR   = 11'b11001000010;
  localparam logic [10:0] OP_STXR   = 11'b11001000000;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ANDS = 11'b11101010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;

  function automatic logic is_i_op(input logic [9:0] op);
    case (op)
      OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
      OP_ANDI, OP_ANDIS, OP_ORRI, OP_EORI: is_i_op = 1'b1;
      default:                             is_i_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_d_op(input logic [10:0] op);
    case (op)
      OP_LDUR, OP_STUR, OP_LDURB, OP_STURB, OP_LDURH,
      OP_STURH, OP_LDURSW, OP_STURW, OP_LDXR, OP_STXR: is_d_op = 1'b1;
      default:                                         is_d_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [10:0] op);
    case (op)
      OP_STUR, OP_STURB, OP_STURH, OP_STURW, OP_STXR: is_store_op = 1'b1;
      default:                                        is_store_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_r_op(input logic [10:0] op);
    case (op)
      OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ANDS,
      OP_ORR, OP_EOR, OP_LSL, OP_LSR, OP_BR, OP_MUL: is_r_op = 1'b1;
      default:                                       is_r_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_extract.sv
// Combinational LEGv8 field decoder: format, register fields, second read
// address and extended immediate for one instruction word.
module instr_field_extract
  import decode_pkg::*;
#(
  parameter int INSTR_LEN  = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic [INSTR_LEN-1:0]  instr,
  output logic [10:0]           opcode,
  output logic [2:0]            fmt,
  output logic [4:0]            rd,
  output logic [4:0]            rn,
  output logic [4:0]            rm,
  output logic [4:0]            reg2,
  output logic [5:0]            shamt,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  illegal
);

  assign opcode = instr[31:21];
  assign rd     = instr[4:0];
  assign rn     = instr[9:5];
  assign rm     = instr[20:16];
  assign shamt  = instr[15:10];

  always_comb begin
    fmt     = FMT_R;
    imm     = '0;
    illegal = 1'b0;
    reg2    = instr[20:16];
    if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      fmt = FMT_B;
      imm = DATA_WIDTH'($signed(instr[25:0]));
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ ||
                 instr[31:24] == OP_BCOND) begin
      fmt  = FMT_CB;
      imm  = DATA_WIDTH'($signed(instr[23:5]));
      reg2 = instr[4:0];
    end else if (instr[31:23] == OP_MOVZ || instr[31:23] == OP_MOVK) begin
      fmt = FMT_IW;
      // hw field selects which 16-bit lane the immediate lands in
      imm = DATA_WIDTH'(instr[20:5]) << {instr[22:21], 4'b0000};
    end else if (is_i_op(instr[31:22])) begin
      fmt = FMT_I;
      imm = DATA_WIDTH'(instr[21:10]);
    end else if (is_d_op(instr[31:21])) begin
      fmt = FMT_D;
      imm = DATA_WIDTH'($signed(instr[20:12]));
      if (is_store_op(instr[31:21])) reg2 = instr[4:0];
    end else if (!is_r_op(instr[31:21])) begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// IF/ID decode stage: decodes the incoming instruction and holds results in a
// two-entry skid buffer so in_ready never depends combinationally on out_ready.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_LEN  = 32,
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_LEN-1:0]  in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [10:0]           out_opcode,
  output logic [2:0]            out_fmt,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rn,
  output logic [4:0]            out_rm,
  output logic [4:0]            out_reg2,
  output logic [5:0]            out_shamt,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_illegal
);

  localparam int BW = PC_WIDTH + 11 + 3 + 5 * 4 + 6 + DATA_WIDTH + 1;

  logic [10:0]           dec_opcode;
  logic [2:0]            dec_fmt;
  logic [4:0]            dec_rd, dec_rn, dec_rm, dec_reg2;
  logic [5:0]            dec_shamt;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  dec_illegal;
  logic [BW-1:0]         dec_bus;

  instr_field_extract #(
    .INSTR_LEN (INSTR_LEN),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_extract (
    .instr  (in_instr),
    .opcode (dec_opcode),
    .fmt    (dec_fmt),
    .rd     (dec_rd),
    .rn     (dec_rn),
    .rm     (dec_rm),
    .reg2   (dec_reg2),
    .shamt  (dec_shamt),
    .imm    (dec_imm),
    .illegal(dec_illegal)
  );

  assign dec_bus = {in_pc, dec_opcode, dec_fmt, dec_rd, dec_rn, dec_rm,
                    dec_reg2, dec_shamt, dec_imm, dec_illegal};

  skid_state_t   state_reg, state_next;
  logic [BW-1:0] main_reg, main_next;
  logic [BW-1:0] skid_reg, skid_next;
  logic          in_ready_reg;
  logic          in_fire, out_fire;

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != SKID_EMPTY);
  assign in_fire   = in_valid & in_ready_reg;
  assign out_fire  = out_valid & out_ready;

  assign {out_pc, out_opcode, out_fmt, out_rd, out_rn, out_rm,
          out_reg2, out_shamt, out_imm, out_illegal} = main_reg;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      SKID_EMPTY: begin
        if (in_fire) begin
          main_next  = dec_bus;
          state_next = SKID_MAIN;
        end
      end
      SKID_MAIN: begin
        if (out_fire) begin
          if (in_fire) main_next = dec_bus;
          else         state_next = SKID_EMPTY;
        end else if (in_fire) begin
          skid_next  = dec_bus;
          state_next = SKID_FULL;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          main_next  = skid_reg;
          state_next = SKID_MAIN;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_reg    <= SKID_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      // Registered ready: accept unless the skid slot will be occupied
      in_ready_reg <= (state_next != SKID_FULL);
    end
  end

endmodule
